rtc_controller: RTL and testbench



---
 rtl/rtc_pkg.sv | 25 ++
 rtl/bcd_wrap_counter.sv | 32 +++
 rtl/rtc_controller.sv | 115 +++++++++++
 tb/tb_rtc_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types, limits and BCD arithmetic for the time-of-day controller.
package rtc_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_HH = 3'd1,
    SET_MM = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } rtc_mode_t;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // Two-digit BCD increment that wraps to 00 after max.
  // The low digit rolls 9->0 and carries into the high digit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max)             r = 8'h00;
    else if (v[3:0] == 4'h9)  r = {v[7:4] + 4'h1, 4'h0};
    else                      r = {v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter that wraps at MAX_BCD and flags the wrap as a carry.
module bcd_wrap_counter
  import rtc_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = MS_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_q, value_d;

  // Next value: step when asked, otherwise hold.
  always_comb begin
    value_d = value_q;
    if (inc) value_d = bcd_inc(value_q, MAX_BCD);
  end

  // Value register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) value_q <= 8'h00;
    else     value_q <= value_d;
  end

  // Carry out in the same cycle the counter rolls over.
  assign wrap  = inc && (value_q == MAX_BCD);
  assign value = value_q;

endmodule

// File: rtl/rtc_controller.sv
// 24-hour HH:MM:SS clock with prescaler, set-mode FSM and a registered alarm match.
module rtc_controller
  import rtc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       alarm_en,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic [7:0] ah_bcd,
  output logic [7:0] am_bcd,
  output logic       sec_tick,
  output logic       alarm,
  output logic [2:0] mode
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] PRESC_LAST = CW'(TICKS_PER_SEC - 1);

  rtc_mode_t     state_q, state_d;
  logic [CW-1:0] presc_q, presc_d;
  logic          alarm_q, alarm_d;

  logic tick, leave_set, inc_ok, time_run;
  logic ss_inc, mm_inc, hh_inc, ah_inc, am_inc;
  logic ss_wrap, mm_wrap, hh_wrap, ah_wrap, am_wrap;
  logic ss_clr;
  logic unused_wraps;

  assign tick      = (presc_q == PRESC_LAST);
  // Leaving SET_MM restarts the second so a freshly set time begins cleanly.
  assign leave_set = mode_btn && (state_q == SET_MM);
  // A mode change in the same cycle swallows the increment.
  assign inc_ok    = inc_btn && !mode_btn;
  // Time advances everywhere except while the time itself is being edited.
  assign time_run  = (state_q == RUN) || (state_q == SET_AH) || (state_q == SET_AM);

  // Prescaler: free-running 0..TICKS_PER_SEC-1, restarted on leaving SET_MM.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    if (leave_set) presc_d = '0;
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  // Mode FSM next state: each mode pulse steps around the ring.
  always_comb begin
    state_d = state_q;
    if (mode_btn) begin
      case (state_q)
        RUN:     state_d = SET_HH;
        SET_HH:  state_d = SET_MM;
        SET_MM:  state_d = SET_AH;
        SET_AH:  state_d = SET_AM;
        default: state_d = RUN;
      endcase
    end
  end

  // Mode FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Increment routing: carries while running, button while editing a field.
  always_comb begin
    ss_inc = time_run && tick;
    mm_inc = time_run ? ss_wrap : ((state_q == SET_MM) && inc_ok);
    hh_inc = time_run ? mm_wrap : ((state_q == SET_HH) && inc_ok);
    ah_inc = (state_q == SET_AH) && inc_ok;
    am_inc = (state_q == SET_AM) && inc_ok;
  end

  assign ss_clr = rst || leave_set;

  bcd_wrap_counter #(.MAX_BCD(MS_MAX)) u_ss (
    .clk(clk), .rst(ss_clr), .inc(ss_inc), .value(ss_bcd), .wrap(ss_wrap));
  bcd_wrap_counter #(.MAX_BCD(MS_MAX)) u_mm (
    .clk(clk), .rst(rst), .inc(mm_inc), .value(mm_bcd), .wrap(mm_wrap));
  bcd_wrap_counter #(.MAX_BCD(HH_MAX)) u_hh (
    .clk(clk), .rst(rst), .inc(hh_inc), .value(hh_bcd), .wrap(hh_wrap));
  bcd_wrap_counter #(.MAX_BCD(HH_MAX)) u_ah (
    .clk(clk), .rst(rst), .inc(ah_inc), .value(ah_bcd), .wrap(ah_wrap));
  bcd_wrap_counter #(.MAX_BCD(MS_MAX)) u_am (
    .clk(clk), .rst(rst), .inc(am_inc), .value(am_bcd), .wrap(am_wrap));

  // Day rollover and alarm-field wraps carry nowhere.
  assign unused_wraps = hh_wrap ^ ah_wrap ^ am_wrap;

  // Alarm match, suppressed while the time is being edited.
  always_comb begin
    alarm_d = alarm_en && time_run && (hh_bcd == ah_bcd) && (mm_bcd == am_bcd);
  end

  // Alarm register: follows the match one cycle late.
  always_ff @(posedge clk) begin
    if (rst) alarm_q <= 1'b0;
    else     alarm_q <= alarm_d;
  end

  assign sec_tick = tick;
  assign alarm    = alarm_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_rtc_controller.sv
// Directed bench for rtc_controller with a 4-cycle second.
module tb_rtc_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       alarm_en = 1'b0;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd, ah_bcd, am_bcd;
  logic       sec_tick, alarm;
  logic [2:0] mode;

  int total = 0;
  int bad   = 0;

  rtc_controller #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn), .alarm_en(alarm_en),
    .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd), .ah_bcd(ah_bcd), .am_bcd(am_bcd),
    .sec_tick(sec_tick), .alarm(alarm), .mode(mode));

  always #5 clk = ~clk;

  // Advance one cycle; sample/drive 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_mode();
    mode_btn = 1'b1; cyc(); mode_btn = 1'b0;
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      inc_btn = 1'b1; cyc(); inc_btn = 1'b0;
    end
  endtask

  // Wait (bounded) for a tick cycle, then step past it so the update is visible.
  task automatic wait_tick();
    int n;
    n = 0;
    while (sec_tick !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    chk("tick_seen", {7'd0, sec_tick}, 8'd1);
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic set_alarm_0001();
    press_mode(); press_mode(); press_mode();   // SET_AH
    press_mode();                               // SET_AM
    press_inc(1);
    press_mode();                               // RUN
  endtask

  initial begin
    // 1. reset and first ticks
    cyc(); cyc(); rst = 1'b0;
    chk("rst_hh", hh_bcd, 8'h00);
    chk("rst_mm", mm_bcd, 8'h00);
    chk("rst_ss", ss_bcd, 8'h00);
    chk("rst_ah", ah_bcd, 8'h00);
    chk("rst_am", am_bcd, 8'h00);
    chk("rst_alarm", {7'd0, alarm}, 8'd0);
    chk("rst_mode", {5'd0, mode}, 8'd0);
    chk("rst_tick", {7'd0, sec_tick}, 8'd0);
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk("t1_tick", {7'd0, sec_tick}, (c % 4 == 3) ? 8'd1 : 8'd0);
      chk("t1_ss", ss_bcd, 8'(c / 4));
    end
    chk("t1_mm", mm_bcd, 8'h00);

    // 2. full-day rollover
    do_reset();
    press_mode();
    chk("t2_mode_hh", {5'd0, mode}, 8'd1);
    press_inc(23);
    chk("t2_hh23", hh_bcd, 8'h23);
    press_mode();
    press_inc(59);
    chk("t2_mm59", mm_bcd, 8'h59);
    chk("t2_hh_nocarry", hh_bcd, 8'h23);
    press_mode(); press_mode(); press_mode();
    chk("t2_mode_run", {5'd0, mode}, 8'd0);
    for (int i = 0; i < 59; i++) wait_tick();
    chk("t2_hh", hh_bcd, 8'h23);
    chk("t2_mm", mm_bcd, 8'h59);
    chk("t2_ss", ss_bcd, 8'h59);
    wait_tick();
    chk("t2_roll_hh", hh_bcd, 8'h00);
    chk("t2_roll_mm", mm_bcd, 8'h00);
    chk("t2_roll_ss", ss_bcd, 8'h00);

    // 3. set-mode freeze
    do_reset();
    for (int i = 0; i < 7; i++) wait_tick();
    chk("t3_ss07", ss_bcd, 8'h07);
    press_mode();
    for (int i = 0; i < 8; i++) wait_tick();
    chk("t3_frz_ss", ss_bcd, 8'h07);
    chk("t3_frz_mm", mm_bcd, 8'h00);
    press_inc(25);
    chk("t3_hh01", hh_bcd, 8'h01);
    press_mode(); press_mode();
    chk("t3_mode_ah", {5'd0, mode}, 8'd3);
    chk("t3_ss_clr", ss_bcd, 8'h00);
    chk("t3_tick_k1", {7'd0, sec_tick}, 8'd0);
    cyc();
    chk("t3_tick_k2", {7'd0, sec_tick}, 8'd0);
    cyc();
    chk("t3_tick_k3", {7'd0, sec_tick}, 8'd0);
    cyc();
    chk("t3_tick_k4", {7'd0, sec_tick}, 8'd1);
    cyc();
    chk("t3_ss01", ss_bcd, 8'h01);
    chk("t3_hh_keep", hh_bcd, 8'h01);

    // 4a. alarm enabled
    alarm_en = 1'b1;
    do_reset();
    set_alarm_0001();
    chk("t4_am", am_bcd, 8'h01);
    chk("t4_alarm_off", {7'd0, alarm}, 8'd0);
    for (int i = 0; i < 60; i++) wait_tick();
    chk("t4_mm01", mm_bcd, 8'h01);
    chk("t4_alarm_lag", {7'd0, alarm}, 8'd0);
    cyc();
    chk("t4_alarm_on", {7'd0, alarm}, 8'd1);
    for (int i = 0; i < 60; i++) wait_tick();
    chk("t4_mm02", mm_bcd, 8'h02);
    chk("t4_alarm_hold", {7'd0, alarm}, 8'd1);
    cyc();
    chk("t4_alarm_fall", {7'd0, alarm}, 8'd0);

    // 4b. alarm disabled
    alarm_en = 1'b0;
    do_reset();
    set_alarm_0001();
    for (int i = 0; i < 60; i++) wait_tick();
    cyc();
    chk("t4b_mm01", mm_bcd, 8'h01);
    chk("t4b_alarm", {7'd0, alarm}, 8'd0);

    // 5. simultaneous pulses
    do_reset();
    press_mode(); press_mode();
    press_inc(5);
    chk("t5_mm05", mm_bcd, 8'h05);
    mode_btn = 1'b1; inc_btn = 1'b1;
    cyc();
    mode_btn = 1'b0; inc_btn = 1'b0;
    chk("t5_mode", {5'd0, mode}, 8'd3);
    chk("t5_mm", mm_bcd, 8'h05);

    // 6. reset mid-operation
    do_reset();
    press_mode(); press_inc(3);
    press_mode(); press_mode();
    press_inc(12);
    press_mode();
    press_inc(34);
    chk("t6_ah", ah_bcd, 8'h12);
    chk("t6_am", am_bcd, 8'h34);
    chk("t6_mode", {5'd0, mode}, 8'd4);
    rst = 1'b1; mode_btn = 1'b1; inc_btn = 1'b1;
    cyc();
    rst = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    chk("t6_rst_mode", {5'd0, mode}, 8'd0);
    chk("t6_rst_hh", hh_bcd, 8'h00);
    chk("t6_rst_ah", ah_bcd, 8'h00);
    chk("t6_rst_am", am_bcd, 8'h00);
    chk("t6_rst_ss", ss_bcd, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
